alu_result_select_reg: RTL and testbench
========================================

Name: alu_result_select_reg

Overview:
Parametrised successor to the 2:1 arithmetic/boolean result multiplexer. Selects one of NUM_SRC functional-unit results, e.g. adder, boolean unit, shifter, comparator, using a per-transaction select field. Derives Zero/Negative and passes through Carry/Overflow for the selected source. Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the ALU output stage sustains one result per clock under back-pressure.

Parameters:
WIDTH, 32, data width of every source and of the result
NUM_SRC, 4, number of selectable sources (2..16)
SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_SRC

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source bundle and sel valid this cycle
in_ready  output  1  block can accept a bundle this cycle
sel  input  SEL_W  source index; 0 = arithmetic, 1 = boolean, others per top level
src_data  input  NUM_SRC*WIDTH  concatenated source results; source i at [i*WIDTH +: WIDTH]
src_carry  input  NUM_SRC  per-source carry-out
src_ovf  input  NUM_SRC  per-source overflow
out_valid  output  1  result registers hold a valid entry
out_ready  input  1  downstream accepts the result
result  output  WIDTH  selected result
flag_zero  output  1  result == 0
flag_neg  output  1  result[WIDTH-1]
flag_carry  output  1  src_carry[sel]
flag_ovf  output  1  src_ovf[sel]
sel_err  output  1  sel >= NUM_SRC for this entry

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, in_ready=1, result=0, all flags=0, sel_err=0. Both buffer entries are invalid.
- Accept: an input is accepted when in_valid && in_ready.
- Select and flags:
  - The selection and the flags are computed combinationally from the accepted inputs and captured into one entry.
  - If sel >= NUM_SRC: result=0, flag_zero=1, flag_neg=0, flag_carry=0, flag_ovf=0, sel_err=1.
- Latency: exactly 1 cycle. A bundle accepted at edge N appears on the outputs after edge N with out_valid=1.
- Buffer states (entry count):
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop -> ONE, with the new entry replacing the old.
  - FULL: pop -> ONE, and the skid entry moves to the output.
  - A pop is out_valid && out_ready.
- in_ready is a registered output: it depends only on state, never combinationally on out_ready.
- Ordering: strict FIFO; the output order matches the accept order.
- Stability: while out_valid && !out_ready, result and every flag stay stable.
- in_valid with in_ready=0: nothing is captured. The source must hold its bundle.
- Reset mid-operation: every entry is discarded immediately and outputs return to reset values asynchronously.

Optional Feature:
Macro ALU_STICKY_FLAGS_EN.
- Defined:
  - Adds input clr_sticky (1 bit) and outputs sticky_ovf and sticky_err (1 bit each).
  - sticky_ovf sets on any pop whose entry has flag_ovf=1; sticky_err sets on any pop whose entry has sel_err=1.
  - Both clear synchronously when clr_sticky=1. A set and a clear in the same cycle leaves the sticky bit at 1.
  - Reset value of both is 0.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Arithmetic select: src0=0x00000002, src1=0x00000000, sel=0, out_ready=1 -> next cycle result=0x00000002, zero=0, neg=0, out_valid=1.
- Boolean select with negative and carry: sel=1, src1=0x80000000, src_carry=4'b0010 -> result=0x80000000, neg=1, carry=1; then src1=0 -> zero=1.
- Back-pressure: out_ready=0, push A=0x11 then B=0x22 -> in_ready=0 after the second accept, result holds 0x11. Raise out_ready -> 0x11 then 0x22 on consecutive cycles, then out_valid=0.
- Illegal select: NUM_SRC=3, sel=3 -> result=0, zero=1, sel_err=1, carry=0, ovf=0.
- Async reset while FULL: drop rst_n mid-cycle -> out_valid=0 and in_ready=1 before the next edge; after release the queue is empty.
- With ALU_STICKY_FLAGS_EN: pop an entry with ovf=1 -> sticky_ovf=1 persists over later clean pops; clr_sticky pulse -> 0.

Source files
------------

// File: rtl/alu_result_select_reg.sv
// Selects one of NUM_SRC unit results, derives flags, registers through a 2-entry skid buffer.
// Optional macro ALU_STICKY_FLAGS_EN adds clr_sticky, sticky_ovf and sticky_err.
module alu_result_select_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_carry,
    input  logic [NUM_SRC-1:0]       src_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     flag_zero,
    output logic                     flag_neg,
    output logic                     flag_carry,
    output logic                     flag_ovf,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic                     clr_sticky,
    output logic                     sticky_ovf,
    output logic                     sticky_err,
`endif
    output logic                     sel_err
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t nxt;
    logic   hit;
    logic   accept;
    logic   pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Loop compare instead of a range check keeps sel_err well defined when NUM_SRC == 2**SEL_W.
    always_comb begin
        nxt = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                hit        = 1'b1;
                nxt.result = src_data[i*WIDTH +: WIDTH];
                nxt.carry  = src_carry[i];
                nxt.ovf    = src_ovf[i];
            end
        end
        nxt.err  = !hit;
        nxt.zero = (nxt.result == '0);
        nxt.neg  = nxt.result[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= nxt;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid     <= nxt;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (!accept && pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (accept && pop) begin
                        head <= nxt;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head     <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign result     = head.result;
    assign flag_zero  = head.zero;
    assign flag_neg   = head.neg;
    assign flag_carry = head.carry;
    assign flag_ovf   = head.ovf;
    assign sel_err    = head.err;

`ifdef ALU_STICKY_FLAGS_EN
    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_err <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf && !clr_sticky) || (pop && head.ovf);
            sticky_err <= (sticky_err && !clr_sticky) || (pop && head.err);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_select_reg.sv
// Directed bench for alu_result_select_reg with NUM_SRC=3 so an illegal select is reachable.
module tb_alu_result_select_reg;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_carry;
    logic [NUM_SRC-1:0]       src_ovf;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         result;
    logic                     flag_zero;
    logic                     flag_neg;
    logic                     flag_carry;
    logic                     flag_ovf;
    logic                     sel_err;
`ifdef ALU_STICKY_FLAGS_EN
    logic                     clr_sticky;
    logic                     sticky_ovf;
    logic                     sticky_err;
`endif

    int total  = 0;
    int passed = 0;

    alu_result_select_reg #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .src_data   (src_data),
        .src_carry  (src_carry),
        .src_ovf    (src_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
`ifdef ALU_STICKY_FLAGS_EN
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .sticky_err (sticky_err),
`endif
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result, zero, neg, carry, ovf, sel_err in one call.
    task automatic chk_out(input string tag, input logic [WIDTH-1:0] r,
                           input logic z, input logic n, input logic c,
                           input logic o, input logic e);
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".zero"}, 64'(flag_zero), 64'(z));
        chk({tag, ".neg"}, 64'(flag_neg), 64'(n));
        chk({tag, ".carry"}, 64'(flag_carry), 64'(c));
        chk({tag, ".ovf"}, 64'(flag_ovf), 64'(o));
        chk({tag, ".sel_err"}, 64'(sel_err), 64'(e));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        src_data  = '0;
        src_carry = '0;
        src_ovf   = '0;
        out_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif
        #12;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_STICKY_FLAGS_EN
        chk("rst.sticky_ovf", 64'(sticky_ovf), 64'd0);
        chk("rst.sticky_err", 64'(sticky_err), 64'd0);
`endif
        rst_n = 1'b1;

        // Arithmetic select
        in_valid = 1'b1;
        sel      = 2'd0;
        src_data = {32'h0, 32'h0, 32'h0000_0002};
        tick();
        chk("arith.out_valid", 64'(out_valid), 64'd1);
        chk("arith.in_ready", 64'(in_ready), 64'd1);
        chk_out("arith", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Boolean select, negative with carry (accept+pop replaces head)
        sel       = 2'd1;
        src_data  = {32'h0, 32'h8000_0000, 32'h0000_0002};
        src_carry = 3'b010;
        tick();
        chk_out("bool_neg", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        src_data = {32'h0, 32'h0, 32'h0000_0002};
        tick();
        chk_out("bool_zero", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Pop without accept drains to empty
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 64'(out_valid), 64'd0);
        chk("drain.in_ready", 64'(in_ready), 64'd1);

        // Back-pressure: two accepts fill, a third offer is ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        src_carry = 3'b000;
        src_data  = {32'h0, 32'h0, 32'h0000_0011};
        tick();
        chk("bp1.out_valid", 64'(out_valid), 64'd1);
        chk("bp1.in_ready", 64'(in_ready), 64'd1);
        chk("bp1.result", 64'(result), 64'h11);
        src_data = {32'h0, 32'h0, 32'h0000_0022};
        tick();
        chk("bp2.in_ready", 64'(in_ready), 64'd0);
        chk("bp2.result", 64'(result), 64'h11);
        src_data = {32'h0, 32'h0, 32'h0000_0033};
        tick();
        chk("bp3.in_ready", 64'(in_ready), 64'd0);
        chk("bp3.result", 64'(result), 64'h11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp4.result", 64'(result), 64'h22);
        chk("bp4.in_ready", 64'(in_ready), 64'd1);
        chk("bp4.out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp5.out_valid", 64'(out_valid), 64'd0);

        // Third source with overflow, all-ones result
        in_valid  = 1'b1;
        sel       = 2'd2;
        src_data  = {32'hFFFF_FFFF, 32'h0, 32'h0};
        src_carry = 3'b010;
        src_ovf   = 3'b100;
        tick();
        chk_out("src2_ovf", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Illegal select; this edge also pops the overflow entry
        sel       = 2'd3;
        src_data  = {32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111};
        src_carry = 3'b111;
        src_ovf   = 3'b111;
        tick();
        chk_out("illegal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky1.ovf", 64'(sticky_ovf), 64'd1);
        chk("sticky1.err", 64'(sticky_err), 64'd0);
`endif

        // Clean entry pops the illegal one
        sel       = 2'd0;
        src_data  = {32'h0, 32'h0, 32'h0000_0005};
        src_carry = 3'b000;
        src_ovf   = 3'b000;
        tick();
        chk_out("clean", 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky2.ovf", 64'(sticky_ovf), 64'd1);
        chk("sticky2.err", 64'(sticky_err), 64'd1);
`endif
        in_valid = 1'b0;
        tick();
        chk("clean_drain.out_valid", 64'(out_valid), 64'd0);
`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky3.ovf", 64'(sticky_ovf), 64'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clr.ovf", 64'(sticky_ovf), 64'd0);
        chk("sticky_clr.err", 64'(sticky_err), 64'd0);
        // Set and clear on the same edge keeps the bit set
        in_valid = 1'b1;
        sel      = 2'd1;
        src_ovf  = 3'b010;
        tick();
        in_valid   = 1'b0;
        src_ovf    = 3'b000;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_setclr.ovf", 64'(sticky_ovf), 64'd1);
`endif

        // Async reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        src_data  = {32'h0, 32'h0, 32'h0000_00AA};
        tick();
        src_data = {32'h0, 32'h0, 32'h0000_00BB};
        tick();
        in_valid = 1'b0;
        chk("full.in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.result", 64'(result), 64'h0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst.out_valid", 64'(out_valid), 64'd0);
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
